// File: rtl/ram_io_responder.sv
// ram_io_responder: byte-serial memory responder with RAM, TX FIFO/streamer, RX latch and status IO window
module ram_io_responder #(
    parameter int ADDR_WIDTH = 17,
    parameter int FIFO_DEPTH = 8,
    parameter int TX_GAP     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_ena,
    input  logic        wr_mc2ram,
    input  logic [31:0] addr_2ram,
    input  logic [7:0]  data_2ram,
    output logic [7:0]  data_from_ram,
    output logic        uart_full_signal,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        tx_overflow,
    output logic        sim_halt
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW:0] DEPTH    = CW'(FIFO_DEPTH);
    localparam logic [PW:0] FULL_LVL = CW'(FIFO_DEPTH - 1);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    logic [7:0] mem [0:(1 << ADDR_WIDTH) - 1];
    logic [7:0] fifo [0:FIFO_DEPTH - 1];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0] count, next_count;
    logic [1:0] state;
    logic [7:0] gap;
    logic rx_valid;
    logic [7:0] rx_byte;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic is_io, data_sel, stat_sel, rd, wr, push, pop;
    logic [7:0] rd_data;
    logic unused_addr;

    assign unused_addr = ^addr_2ram[31:18];
    assign in_ready = !rx_valid;

    // a full FIFO still accepts a write on the same edge the head is popped
    always_comb begin
        is_io = addr_2ram[17:16] == 2'b11;
        ram_addr = addr_2ram[ADDR_WIDTH-1:0];
        data_sel = is_io && addr_2ram[2:0] == 3'd0;
        stat_sel = is_io && addr_2ram[2:0] == 3'd4;
        rd = ram_ena && !wr_mc2ram;
        wr = ram_ena && wr_mc2ram;
        pop = state == S_SEND && tx_ready;
        push = wr && data_sel && (count < DEPTH || pop);
        next_count = count + CW'(push) - CW'(pop);
        rd_data = !is_io ? mem[ram_addr] :
                  data_sel ? (rx_valid ? rx_byte : 8'h00) :
                  stat_sel ? {6'b0, uart_full_signal, rx_valid} : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (wr && !is_io) mem[ram_addr] <= data_2ram;
    end

    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= data_2ram;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_from_ram <= 8'h00;
            uart_full_signal <= 1'b0;
            tx_valid <= 1'b0;
            tx_data <= 8'h00;
            tx_overflow <= 1'b0;
            sim_halt <= 1'b0;
            rx_valid <= 1'b0;
            rx_byte <= 8'h00;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            state <= S_IDLE;
            gap <= 8'd0;
        end else begin
            if (rd) data_from_ram <= rd_data;
            if (rd && data_sel && rx_valid) rx_valid <= 1'b0;
            else if (in_valid && !rx_valid) begin
                rx_valid <= 1'b1;
                rx_byte <= in_data;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= next_count;
            uart_full_signal <= next_count >= FULL_LVL;
            if (wr && data_sel && !push) tx_overflow <= 1'b1;
            if (wr && stat_sel) sim_halt <= 1'b1;
            // the IDLE cycle after GAP is itself one of the TX_GAP idle cycles
            case (state)
                S_IDLE: if (count != '0) begin
                    state <= S_SEND;
                    tx_valid <= 1'b1;
                    tx_data <= fifo[rd_ptr];
                end
                S_SEND: if (tx_ready) begin
                    tx_valid <= 1'b0;
                    state <= TX_GAP >= 2 ? S_GAP : S_IDLE;
                    gap <= 8'(TX_GAP - 1);
                end
                S_GAP: begin
                    gap <= gap - 8'd1;
                    state <= gap <= 8'd1 ? S_IDLE : S_GAP;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
